ser_piso_buf: RTL

SER_PISO_BUF -- requirements
Module: ser_piso_buf

---
 rtl/ser_piso_buf.sv | 136 +++++++++++++
 1 files changed

// File: rtl/ser_piso_buf.sv
// Parallel-in serial-out shifter with one holding buffer, paced by an external bit-rate tick.
// Latency: first bit appears the cycle after the first tick following a load; bits change only on ticks.
// Backpressure: ld_ready drops while the holding buffer is full or ser_en is low; loads are refused then.
module ser_piso_buf #(
  parameter int   DATA_WIDTH = 8,
  parameter bit   MSB_FIRST  = 1'b0,
  parameter logic IDLE_VAL   = 1'b0,
  localparam int  LW         = $clog2(DATA_WIDTH + 1)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  ser_en,
  input  logic                  tick,
  input  logic                  ld_valid,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic [LW-1:0]         DLEN,
  output logic                  ld_ready,
  output logic                  ser_data,
  output logic                  ser_busy,
  output logic                  ser_done
);

  typedef enum logic {IDLE, SHIFT} state_t;

  localparam logic [LW-1:0] ONE    = LW'(1);
  localparam logic [LW-1:0] FULL_W = LW'(DATA_WIDTH);

  state_t                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   buf_dat_q, buf_dat_d;
  logic [LW-1:0]           buf_len_q, buf_len_d;
  logic                    buf_full_q, buf_full_d;
  logic [DATA_WIDTH-1:0]   sh_q, sh_d;
  logic [LW-1:0]           cnt_q, cnt_d;
  logic [LW-1:0]           len_q, len_d;
  logic                    sdat_q, sdat_d;
  logic                    done_q, done_d;

  logic                    ld_fire;
  logic                    word_end;
  logic                    done_evt;

  // Select bit idx of a word; a shift avoids a narrow-index part-select.
  function automatic logic pick(input logic [DATA_WIDTH-1:0] w, input logic [LW-1:0] idx);
    logic [DATA_WIDTH-1:0] s;
    s = w >> idx;
    return s[0];
  endfunction

  assign ld_ready = ser_en && !buf_full_q;
  assign ser_data = sdat_q;
  assign ser_busy = (state_q == SHIFT);
  assign ser_done = done_q;

  // Next-state: enable-abort, tick-driven shifting/handover, and buffer loading.
  always_comb begin
    state_d    = state_q;
    buf_dat_d  = buf_dat_q;
    buf_len_d  = buf_len_q;
    buf_full_d = buf_full_q;
    sh_d       = sh_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    sdat_d     = sdat_q;
    done_evt   = 1'b0;
    ld_fire    = ld_valid && ld_ready;
    word_end   = (state_q == SHIFT) && (cnt_q == len_q);

    if (!ser_en) begin
      state_d    = IDLE;
      buf_dat_d  = '0;
      buf_len_d  = '0;
      buf_full_d = 1'b0;
      sh_d       = '0;
      cnt_d      = '0;
      len_d      = '0;
      sdat_d     = IDLE_VAL;
    end else begin
      if (tick) begin
        if ((state_q == SHIFT) && !word_end) begin
          // Mid-word: emit the next bit in the configured order.
          sdat_d = pick(sh_q, MSB_FIRST ? (len_q - cnt_q - ONE) : cnt_q);
          cnt_d  = cnt_q + ONE;
        end else if (buf_full_q) begin
          // Start from idle, or hand over back-to-back with no idle gap.
          state_d    = SHIFT;
          sh_d       = buf_dat_q;
          len_d      = buf_len_q;
          cnt_d      = ONE;
          sdat_d     = pick(buf_dat_q, MSB_FIRST ? (buf_len_q - ONE) : '0);
          buf_full_d = 1'b0;
          buf_dat_d  = '0;
          buf_len_d  = '0;
          done_evt   = word_end;
        end else if (word_end) begin
          state_d  = IDLE;
          sdat_d   = IDLE_VAL;
          done_evt = 1'b1;
        end
      end
      // Load only ever targets an empty buffer, so it never collides with a handover.
      if (ld_fire) begin
        buf_dat_d  = P_DATA;
        buf_len_d  = ((DLEN == '0) || (DLEN > FULL_W)) ? FULL_W : DLEN;
        buf_full_d = 1'b1;
      end
    end
    // A done pulse is never stretched across two cycles, even with back-to-back ticks.
    done_d = done_evt && !done_q;
  end

  // State register with synchronous reset taking priority over everything.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      buf_dat_q  <= '0;
      buf_len_q  <= '0;
      buf_full_q <= 1'b0;
      sh_q       <= '0;
      cnt_q      <= '0;
      len_q      <= '0;
      sdat_q     <= IDLE_VAL;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      buf_dat_q  <= buf_dat_d;
      buf_len_q  <= buf_len_d;
      buf_full_q <= buf_full_d;
      sh_q       <= sh_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      sdat_q     <= sdat_d;
      done_q     <= done_d;
    end
  end

endmodule
